// File: rtl/dmap_wback_walloc_cache.sv
// Direct-mapped, write-back, write-allocate cache with one word per line.
// The CPU side is a request/held-strobe interface completed by a single
// cpu_ready pulse; the memory side is a registered request held until mem_ready.
module dmap_wback_walloc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_WIDTH - 2 - INDEX_W;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    // Request captured at acceptance; CPU inputs are ignored afterwards.
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_W-1:0]     req_wstrb;
    logic                  req_write;
    logic                  first_compare;

    // Line storage: only the valid/dirty bits need a defined reset value.
    logic [NUM_LINES-1:0]  valid_bits;
    logic [NUM_LINES-1:0]  dirty_bits;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic [DATA_WIDTH-1:0] merged_data;
    logic                  line_valid;
    logic                  line_dirty;
    logic                  hit;
    logic                  accept;
    logic                  fill_line;
    logic                  write_hit;

    logic                  mem_read_next;
    logic                  mem_write_next;
    logic [ADDR_WIDTH-1:0] mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_next;
    logic [STRB_W-1:0]     mem_wstrb_next;

    assign req_index  = req_addr[2 +: INDEX_W];
    assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign line_tag   = tag_mem[req_index];
    assign line_data  = data_mem[req_index];
    assign line_valid = valid_bits[req_index];
    assign line_dirty = dirty_bits[req_index];
    assign hit        = line_valid && (line_tag == req_tag);
    assign accept     = (state == IDLE) && (cpu_read || cpu_write);

    // Byte-merge the latched store data into the current line contents.
    always_comb begin
        merged_data = line_data;
        for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b]) merged_data[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    // Next-state, next memory-request values and the combinational CPU response.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_next     = state;
        mem_read_next  = mem_read;
        mem_write_next = mem_write;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_wstrb_next = mem_wstrb;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        fill_line      = 1'b0;
        write_hit      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_read || cpu_write) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready  = 1'b1;
                    cpu_rdata  = line_data;
                    write_hit  = req_write;
                    state_next = IDLE;
                end else if (line_valid && line_dirty) begin
                    state_next     = WRITEBACK;
                    mem_write_next = 1'b1;
                    mem_addr_next  = {line_tag, req_index, 2'b00};
                    mem_wdata_next = line_data;
                    mem_wstrb_next = '1;
                end else begin
                    state_next    = ALLOCATE;
                    mem_read_next = 1'b1;
                    mem_addr_next = req_addr & WORD_MASK;
                end
            end
            WRITEBACK: begin
                // Drop the write entirely; the refill read is raised one cycle
                // later so the memory sees a clean gap between the two requests.
                if (mem_ready) begin
                    state_next     = ALLOCATE;
                    mem_write_next = 1'b0;
                    mem_addr_next  = '0;
                    mem_wdata_next = '0;
                    mem_wstrb_next = '0;
                end
            end
            ALLOCATE: begin
                if (!mem_read) begin
                    mem_read_next = 1'b1;
                    mem_addr_next = req_addr & WORD_MASK;
                end else if (mem_ready) begin
                    fill_line     = 1'b1;
                    state_next    = COMPARE;
                    mem_read_next = 1'b0;
                    mem_addr_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered memory-side request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_next;
            mem_read  <= mem_read_next;
            mem_write <= mem_write_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            mem_wstrb <= mem_wstrb_next;
        end
    end

    // Capture the request on acceptance and track whether this is its first compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr      <= '0;
            req_wdata     <= '0;
            req_wstrb     <= '0;
            req_write     <= 1'b0;
            first_compare <= 1'b0;
        end else if (accept) begin
            req_addr      <= cpu_addr;
            req_wdata     <= cpu_wdata;
            req_wstrb     <= cpu_wstrb;
            req_write     <= cpu_write;
            first_compare <= 1'b1;
        end else if (fill_line) begin
            first_compare <= 1'b0;
        end
    end

    // Saturating hit/miss counters, updated only on the first compare of a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE && first_compare) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Valid and dirty bits: set on refill / store hit, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_line) begin
            valid_bits[req_index] <= 1'b1;
            dirty_bits[req_index] <= 1'b0;
        end else if (write_hit) begin
            dirty_bits[req_index] <= 1'b1;
        end
    end

    // Tag and data arrays: refill from memory or merge a store hit.
    // NOTE: the arrays have no reset; valid_bits gates their use, so they map to plain RAM.
    always_ff @(posedge clk) begin
        if (fill_line) begin
            data_mem[req_index] <= mem_rdata;
            tag_mem[req_index]  <= req_tag;
        end else if (write_hit) begin
            data_mem[req_index] <= merged_data;
        end
    end

endmodule
